mem_issue_arb: RTL and testbench

- Two-requester arbiter and issue register in front of MemCalc_m.
- Load-issue and store-issue paths each present a packed micro-op. The block grants one per cycle round-robin and holds it in a single output register that feeds MemCalc_m's i_instr.
- Applies branch kill and resolve to held and incoming micro-ops using the packet's brmask field, so squashed memory ops never reach the address calculator.

---
 rtl/mem_issue_arb.sv | 92 +++++++++
 tb/tb_mem_issue_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_arb.sv
// Two-port round-robin arbiter feeding a single issue register for MemCalc_m.
// Branch kill/resolve is applied to both the held micro-op and the one being
// captured, so squashed memory ops never reach the address calculator.
module mem_issue_arb #(
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 6,
  parameter int WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 7 + 10 + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_ld_instr,
  input  logic                 i_ld_valid,
  output logic                 o_ld_ready,
  input  logic [WIDTH-1:0]     i_st_instr,
  input  logic                 i_st_valid,
  output logic                 o_st_ready,
  input  logic                 i_mem_ready,
  input  logic                 i_br_valid,
  input  logic                 i_br_kill,
  input  logic [WIDTH_BRM-1:0] i_br_tag,
  output logic [WIDTH-1:0]     o_instr,
  output logic                 o_grant_st
);

  localparam int BRM_HI = WIDTH - 12;
  localparam int BRM_LO = WIDTH - 11 - WIDTH_BRM;
  localparam int VLD    = WIDTH - 1;

  logic [WIDTH-1:0]     instr_q, instr_d;
  logic                 grant_st_q, grant_st_d;
  logic                 prio_st_q, prio_st_d;   // 1: store wins a tie

  logic                 held_valid, free, grant_ld, grant_st, capture;
  logic                 br_kill, br_res;
  logic [WIDTH-1:0]     in_pkt;
  logic [WIDTH_BRM-1:0] in_brm, held_brm;

  // Arbitration, branch filtering and next-state of the issue register.
  always_comb begin
    held_valid = instr_q[VLD];
    free       = ~held_valid | i_mem_ready;
    grant_ld   = i_ld_valid & (~i_st_valid | ~prio_st_q);
    grant_st   = i_st_valid & (~i_ld_valid |  prio_st_q);
    capture    = free & (grant_ld | grant_st);
    br_kill    = i_br_valid & i_br_kill;
    br_res     = i_br_valid & ~i_br_kill;
    in_pkt     = grant_st ? i_st_instr : i_ld_instr;
    in_brm     = in_pkt[BRM_HI:BRM_LO];
    held_brm   = instr_q[BRM_HI:BRM_LO];

    o_ld_ready = free & grant_ld;
    o_st_ready = free & grant_st;

    instr_d    = instr_q;
    grant_st_d = grant_st_q;
    prio_st_d  = prio_st_q;

    if (capture) begin
      // A killed incoming op still completes its handshake and moves the
      // pointer; it simply lands with the valid bit clear.
      instr_d                = in_pkt;
      instr_d[BRM_HI:BRM_LO] = br_res ? (in_brm & ~i_br_tag) : in_brm;
      instr_d[VLD]           = ~(br_kill & (|(in_brm & i_br_tag)));
      grant_st_d             = grant_st;
      // Pointing at the port not just granted also covers the tie case.
      prio_st_d              = grant_ld;
    end else if (held_valid) begin
      if (i_mem_ready | (br_kill & (|(held_brm & i_br_tag)))) begin
        instr_d[VLD] = 1'b0;
      end else if (br_res) begin
        instr_d[BRM_HI:BRM_LO] = held_brm & ~i_br_tag;
      end
    end
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      instr_q    <= '0;
      grant_st_q <= 1'b0;
      prio_st_q  <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      grant_st_q <= grant_st_d;
      prio_st_q  <= prio_st_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_grant_st = grant_st_q;

endmodule

// File: tb/tb_mem_issue_arb.sv
// Self-checking bench for mem_issue_arb: directed stimulus, a transaction-level
// reference model checked every cycle, and pinned literal expectations.
module tb_mem_issue_arb;

  localparam int WR = 7;
  localparam int WB = 6;
  localparam int W  = 4*32 + WR + WB + 7 + 10 + 1;

  // Field offsets, LSB first: op1, op2, rd, imm, pc, uop, brmask, func, valid.
  localparam int OP1  = 0;
  localparam int OP2  = 32;
  localparam int RD   = 64;
  localparam int IMM  = RD + WR;
  localparam int PC   = IMM + 32;
  localparam int UOP  = PC + 32;
  localparam int BRM  = UOP + 7;
  localparam int FUNC = BRM + WB;
  localparam int VAL  = W - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  ld_instr, st_instr;
  logic          ld_valid, st_valid, ld_ready, st_ready;
  logic          mem_ready, br_valid, br_kill;
  logic [WB-1:0] br_tag;
  logic [W-1:0]  o_instr;
  logic          o_grant_st;

  mem_issue_arb #(.WIDTH_REG(WR), .WIDTH_BRM(WB), .WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ld_instr (ld_instr),
    .i_ld_valid (ld_valid),
    .o_ld_ready (ld_ready),
    .i_st_instr (st_instr),
    .i_st_valid (st_valid),
    .o_st_ready (st_ready),
    .i_mem_ready(mem_ready),
    .i_br_valid (br_valid),
    .i_br_kill  (br_kill),
    .i_br_tag   (br_tag),
    .o_instr    (o_instr),
    .o_grant_st (o_grant_st)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Pinned literal expectations, set by the stimulus for the current cycle.
  logic [W-1:0] pin_mask = '0;
  logic [W-1:0] pin_val  = '0;
  int           pin_ldr  = -1;
  int           pin_str  = -1;
  int           pin_gst  = -1;
  string        pin_name = "";

  // Reference model: the held op (if any), its source, and who was granted last.
  logic         m_known = 1'b0, n_known = 1'b0;
  logic         m_valid = 1'b0, n_valid = 1'b0;
  logic         m_exact = 1'b0, n_exact = 1'b0;
  logic [W-1:0] m_pkt = '0, n_pkt = '0;
  logic         m_gst = 1'b0, n_gst = 1'b0;
  int           m_last = 1, n_last = 1;   // 1: store granted last, load wins a tie

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic          free_e, hit;
    int            win;
    logic [WB-1:0] brm;
    free_e = !m_valid || mem_ready;
    if (ld_valid && st_valid) win = (m_last == 1) ? 0 : 1;
    else if (ld_valid)        win = 0;
    else if (st_valid)        win = 1;
    else                      win = -1;

    if (m_known) begin
      check("ld_ready", W'(ld_ready), W'(free_e && win == 0));
      check("st_ready", W'(st_ready), W'(free_e && win == 1));
      if (m_valid) begin
        check("instr", o_instr, m_pkt);
        check("grant_st", W'(o_grant_st), W'(m_gst));
      end else if (m_exact) begin
        check("instr_zero", o_instr, '0);
        check("grant_st_zero", W'(o_grant_st), '0);
      end else begin
        check("valid_bit", W'(o_instr[VAL]), '0);
      end
      if (pin_mask != '0) check(pin_name, o_instr & pin_mask, pin_val);
      if (pin_ldr >= 0) check({pin_name, "_ldr"}, W'(ld_ready), W'(pin_ldr[0]));
      if (pin_str >= 0) check({pin_name, "_str"}, W'(st_ready), W'(pin_str[0]));
      if (pin_gst >= 0) check({pin_name, "_gst"}, W'(o_grant_st), W'(pin_gst[0]));
    end

    n_known = m_known || !rst_n;
    n_valid = m_valid; n_exact = m_exact; n_pkt = m_pkt; n_gst = m_gst; n_last = m_last;
    if (!rst_n) begin
      n_valid = 1'b0; n_exact = 1'b1; n_pkt = '0; n_gst = 1'b0; n_last = 1;
    end else if (m_known) begin
      if (free_e && win >= 0) begin
        n_pkt = (win == 1) ? st_instr : ld_instr;
        brm   = n_pkt[BRM +: WB];
        hit   = br_valid && br_kill && ((brm & br_tag) != 0);
        if (br_valid && !br_kill) n_pkt[BRM +: WB] = brm & ~br_tag;
        n_pkt[VAL] = 1'b1;
        n_valid    = !hit;
        n_exact    = !hit;
        n_gst      = (win == 1);
        n_last     = win;
      end else if (m_valid) begin
        brm = m_pkt[BRM +: WB];
        if (mem_ready || (br_valid && br_kill && ((brm & br_tag) != 0))) begin
          n_valid = 1'b0;
          n_exact = 1'b0;
        end else if (br_valid && !br_kill) begin
          n_pkt[BRM +: WB] = brm & ~br_tag;
        end
      end
    end
  end

  always @(posedge clk) begin
    m_known <= n_known; m_valid <= n_valid; m_exact <= n_exact;
    m_pkt   <= n_pkt;   m_gst   <= n_gst;   m_last  <= n_last;
  end

  function automatic logic [W-1:0] mk(input logic [31:0] op1, input logic [31:0] op2,
                                      input logic [WR-1:0] rd, input logic [31:0] imm,
                                      input logic [31:0] pc, input logic [6:0] uop,
                                      input logic [WB-1:0] brm, input logic [9:0] func);
    logic [W-1:0] p;
    p = '0;   // incoming valid field left 0: the port valid is authoritative
    p[OP1 +: 32] = op1;  p[OP2 +: 32] = op2;  p[RD +: WR] = rd;
    p[IMM +: 32] = imm;  p[PC +: 32]  = pc;   p[UOP +: 7] = uop;
    p[BRM +: WB] = brm;  p[FUNC +: 10] = func;
    return p;
  endfunction

  task automatic pin_fld(input string nm, input int off, input int wdt, input logic [63:0] v);
    pin_name = nm;
    for (int i = 0; i < wdt; i++) begin
      pin_mask[off+i] = 1'b1;
      pin_val[off+i]  = v[i];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    pin_mask = '0; pin_val = '0; pin_ldr = -1; pin_str = -1; pin_gst = -1;
  endtask

  task automatic idle();
    ld_valid = 0; st_valid = 0; br_valid = 0; br_kill = 0; br_tag = '0; mem_ready = 1;
    cyc();
  endtask

  initial begin
    rst_n = 0; ld_instr = '0; st_instr = '0; ld_valid = 0; st_valid = 0;
    mem_ready = 0; br_valid = 0; br_kill = 0; br_tag = '0;
    cyc(); cyc();

    // Reset state
    pin_fld("rst_state", 0, 64, 64'd0); pin_fld("rst_state", 64, W-64, 64'd0); pin_gst = 0;
    cyc();

    // Single load after reset
    rst_n = 1; mem_ready = 1;
    ld_instr = mk(32'd1, 32'd0, 7'd3, 32'd1, 32'h100, 7'b0000011, 6'd0, 10'b010);
    ld_valid = 1; pin_name = "t1_accept"; pin_ldr = 1; pin_str = 0;
    cyc();
    ld_valid = 0;
    pin_fld("t1_issue", OP1, 32, 64'd1); pin_fld("t1_issue", RD, WR, 64'd3);
    pin_fld("t1_issue", VAL, 1, 64'd1); pin_gst = 0;
    cyc();
    pin_fld("t1_drain", VAL, 1, 64'd0);
    cyc();

    // Both valid back-to-back after reset: L,S,L,S,... with no bubble
    rst_n = 0; cyc(); rst_n = 1;
    ld_instr = mk(32'd100, 32'd0, 7'd5, 32'd0, 32'h200, 7'b0000011, 6'd0, 10'd2);
    st_instr = mk(32'd0, 32'd200, 7'd0, 32'd4, 32'h300, 7'b0100011, 6'd0, 10'd2);
    ld_valid = 1; st_valid = 1; mem_ready = 1;
    for (int k = 0; k < 6; k++) begin
      pin_name = "t2_alt"; pin_ldr = (k % 2 == 0); pin_str = (k % 2 == 1);
      if (k > 0) begin
        pin_fld("t2_alt", VAL, 1, 64'd1);
        pin_gst = (k % 2 == 0);
      end
      cyc();
      if (k % 2 == 1) st_instr = mk(32'd0, 32'd201 + k, 7'd0, 32'd4, 32'h300, 7'b0100011, 6'd0, 10'd2);
      else            ld_instr = mk(32'd101 + k, 32'd0, 7'd5, 32'd0, 32'h200, 7'b0000011, 6'd0, 10'd2);
    end
    idle(); idle();

    // Store held with mem_ready low blocks the load
    st_instr = mk(32'd0, 32'd3, 7'd0, 32'd8, 32'h400, 7'b0100011, 6'd0, 10'd2);
    st_valid = 1; mem_ready = 0; pin_name = "t3_st"; pin_str = 1;
    cyc();
    st_valid = 0;
    ld_instr = mk(32'd77, 32'd0, 7'd9, 32'd0, 32'h500, 7'b0000011, 6'd0, 10'd2);
    ld_valid = 1;
    for (int k = 0; k < 3; k++) begin
      pin_fld("t3_hold", OP2, 32, 64'd3); pin_fld("t3_hold", VAL, 1, 64'd1);
      pin_ldr = 0; pin_gst = 1;
      cyc();
    end
    mem_ready = 1; pin_name = "t3_release"; pin_ldr = 1;
    cyc();
    ld_valid = 0; mem_ready = 0;
    pin_fld("t3_ld", OP1, 32, 64'd77); pin_fld("t3_ld", VAL, 1, 64'd1); pin_gst = 0;
    cyc();
    idle();

    // Kill of held entry: overlapping and non-overlapping masks
    ld_instr = mk(32'd11, 32'd0, 7'd1, 32'd0, 32'h600, 7'b0000011, 6'b000100, 10'd2);
    ld_valid = 1; mem_ready = 0;
    cyc();
    ld_valid = 0; br_valid = 1; br_kill = 1; br_tag = 6'b000100;
    pin_fld("t4_before_kill", VAL, 1, 64'd1);
    cyc();
    br_valid = 0; br_kill = 0;
    pin_fld("t4_killed", VAL, 1, 64'd0);
    cyc();
    ld_instr = mk(32'd12, 32'd0, 7'd1, 32'd0, 32'h604, 7'b0000011, 6'b000010, 10'd2);
    ld_valid = 1;
    cyc();
    ld_valid = 0; br_valid = 1; br_kill = 1; br_tag = 6'b000100;
    cyc();
    br_valid = 0; br_kill = 0;
    pin_fld("t4_survive", VAL, 1, 64'd1); pin_fld("t4_survive", BRM, WB, 64'b000010);
    cyc();
    br_valid = 1; br_kill = 1; br_tag = 6'b000011;
    cyc();
    br_valid = 0; br_kill = 0;
    pin_fld("t4_multitag", VAL, 1, 64'd0);
    cyc();
    // Kill of the incoming packet: handshake completes, packet discarded
    ld_instr = mk(32'd13, 32'd0, 7'd1, 32'd0, 32'h608, 7'b0000011, 6'b001000, 10'd2);
    ld_valid = 1; br_valid = 1; br_kill = 1; br_tag = 6'b001000;
    pin_name = "t4_in_kill"; pin_ldr = 1;
    cyc();
    ld_valid = 0; br_valid = 0; br_kill = 0;
    pin_fld("t4_in_dropped", VAL, 1, 64'd0);
    cyc();

    // Resolve during capture, then resolve on the held entry
    ld_instr = mk(32'd14, 32'd0, 7'd2, 32'd0, 32'h700, 7'b0000011, 6'b000101, 10'd2);
    ld_valid = 1; br_valid = 1; br_kill = 0; br_tag = 6'b000100; mem_ready = 0;
    cyc();
    ld_valid = 0; br_tag = 6'b000001;
    pin_fld("t5_res_cap", BRM, WB, 64'b000001); pin_fld("t5_res_cap", VAL, 1, 64'd1);
    cyc();
    br_valid = 0; br_tag = '0;
    pin_fld("t5_res_held", BRM, WB, 64'b000000); pin_fld("t5_res_held", VAL, 1, 64'd1);
    cyc();
    idle();

    // Reset during a capture
    ld_instr = mk(32'd21, 32'd0, 7'd4, 32'd0, 32'h800, 7'b0000011, 6'd0, 10'd2);
    st_instr = mk(32'd0, 32'd22, 7'd0, 32'd0, 32'h900, 7'b0100011, 6'd0, 10'd2);
    ld_valid = 1; st_valid = 1; mem_ready = 1;
    cyc();
    st_valid = 1; rst_n = 0;
    cyc();
    rst_n = 1;
    pin_fld("t6_rst", 0, 64, 64'd0); pin_fld("t6_rst", 64, W-64, 64'd0);
    pin_gst = 0; pin_ldr = 1; pin_str = 0;
    cyc();
    ld_valid = 0; st_valid = 0;
    pin_fld("t6_after", OP1, 32, 64'd21); pin_fld("t6_after", VAL, 1, 64'd1); pin_gst = 0;
    cyc();
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
